// File: rtl/cfg_types_pkg.sv
// Shared types and constants for the accelerator wrapper and its APB control block.
package cfg_types_pkg;

  // Accelerator-side status types
  typedef enum logic [1:0] {
    ACC_IDLE   = 2'd0,
    ACC_CONFIG = 2'd1,
    ACC_RUN    = 2'd2,
    ACC_DONE   = 2'd3
  } acc_state_t;

  typedef enum logic [1:0] {
    ACC_ERR_NONE     = 2'd0,
    ACC_ERR_OVERFLOW = 2'd1,
    ACC_ERR_ADDR     = 2'd2,
    ACC_ERR_PROTO    = 2'd3
  } acc_error_t;

  // Register offsets within the register half of the APB window
  localparam int unsigned ACC_REG_OFF_W = 12;
  localparam logic [ACC_REG_OFF_W-1:0] ACC_REG_CTRL   = 12'h000;
  localparam logic [ACC_REG_OFF_W-1:0] ACC_REG_STATUS = 12'h004;
  localparam logic [ACC_REG_OFF_W-1:0] ACC_REG_CFG    = 12'h008;
  localparam logic [ACC_REG_OFF_W-1:0] ACC_REG_IRQEN  = 12'h00C;

  // CTRL bit positions
  localparam int unsigned CTRL_GO_BIT  = 0;
  localparam int unsigned CTRL_CLR_BIT = 1;

  // STATUS bit positions
  localparam int unsigned STATUS_BUSY_BIT  = 0;
  localparam int unsigned STATUS_DONE_BIT  = 1;
  localparam int unsigned STATUS_TMO_BIT   = 2;
  localparam int unsigned STATUS_STATE_LSB = 8;
  localparam int unsigned STATUS_ERROR_LSB = 16;

  // Run watchdog counter width
  localparam int unsigned RUN_CNT_W = 16;

  typedef enum logic {
    APB_IDLE     = 1'b0,
    APB_MRD_WAIT = 1'b1
  } apb_st_t;

  typedef enum logic {
    RUN_STOPPED = 1'b0,
    RUN_RUNNING = 1'b1
  } run_st_t;

endpackage

// File: rtl/accel_run_ctrl.sv
// Accelerator run sequencer: holds start for the run, watchdog abort, sticky flags.
module accel_run_ctrl
  import cfg_types_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go,
  input  logic clr,
  input  logic done,
  output logic start,
  output logic done_flag,
  output logic timeout_flag
);

  localparam int unsigned CMP_W = RUN_CNT_W + 1;

  run_st_t               state;
  run_st_t               state_next;
  logic [RUN_CNT_W-1:0]  run_cnt;
  logic                  expire;
  logic                  launch;

  // Watchdog fires on the running cycle that brings the count up to the limit
  always_comb begin
    expire = (TIMEOUT_CYCLES != 0) &&
             ((CMP_W'(run_cnt) + CMP_W'(1)) >= CMP_W'(TIMEOUT_CYCLES));
    launch = (state == RUN_STOPPED) && go;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN_STOPPED;
    else        state <= state_next;
  end

  // Next-state: done takes priority over the watchdog, both end the run
  always_comb begin
    state_next = state;
    case (state)
      RUN_STOPPED: if (go) state_next = RUN_RUNNING;
      RUN_RUNNING: if (done || expire) state_next = RUN_STOPPED;
      default:     state_next = RUN_STOPPED;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    start = 1'b0;
    if (state == RUN_RUNNING) start = 1'b1;
  end

  // Run counter and sticky flags; CLR lands before GO or completion in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt      <= '0;
      done_flag    <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      if (launch) begin
        run_cnt <= '0;
      end else if ((state == RUN_RUNNING) && (run_cnt != '1)) begin
        run_cnt <= run_cnt + RUN_CNT_W'(1);
      end

      if (clr) begin
        done_flag    <= 1'b0;
        timeout_flag <= 1'b0;
      end
      if (launch) done_flag <= 1'b0;
      if (state == RUN_RUNNING) begin
        if (done)        done_flag    <= 1'b1;
        else if (expire) timeout_flag <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/accel_apb_ctrl.sv
// APB slave fronting the accelerator: control/status registers plus guarded RAM window.
module accel_apb_ctrl
  import cfg_types_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 13,
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned MEM_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [APB_ADDR_WIDTH-1:0]   PADDR,
  input  logic [MEM_DATA_WIDTH-1:0]   PWDATA,
  input  logic                        PWRITE,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  output logic [MEM_DATA_WIDTH-1:0]   PRDATA,
  output logic                        PREADY,
  output logic                        PSLVERR,
  output logic                        start,
  input  logic                        done,
  output logic [7:0]                  max_cnt,
  output logic [7:0]                  incr,
  input  acc_state_t                  accel_state,
  input  acc_error_t                  accel_error,
  output logic                        mem_en,
  output logic [MEM_ADDR_WIDTH-1:0]   mem_addr,
  output logic                        mem_we,
  output logic [MEM_DATA_WIDTH/8-1:0] mem_be,
  output logic [MEM_DATA_WIDTH-1:0]   mem_wdata,
  input  logic [MEM_DATA_WIDTH-1:0]   mem_rdata,
  output logic                        irq_o
);

  localparam int unsigned STATUS_W = 32;

  apb_st_t                   apb_st;
  apb_st_t                   apb_next;
  logic                      access;
  logic                      is_mem;
  logic [ACC_REG_OFF_W-1:0]  reg_off;
  logic [STATUS_W-1:0]       status_word;
  logic                      ctrl_we;
  logic                      cfg_we;
  logic                      irqen_we;
  logic                      ctrl_go;
  logic                      ctrl_clr;
  logic                      irq_en;
  logic                      done_flag;
  logic                      timeout_flag;

  // Access decode and STATUS image
  always_comb begin
    access  = PSEL && PENABLE;
    is_mem  = PADDR[APB_ADDR_WIDTH-1];
    reg_off = PADDR[ACC_REG_OFF_W-1:0];
    status_word = '0;
    status_word[STATUS_BUSY_BIT] = start;
    status_word[STATUS_DONE_BIT] = done_flag;
    status_word[STATUS_TMO_BIT]  = timeout_flag;
    status_word[STATUS_STATE_LSB +: 8] = 8'(accel_state);
    status_word[STATUS_ERROR_LSB +: 8] = 8'(accel_error);
    ctrl_go  = ctrl_we && PWDATA[CTRL_GO_BIT];
    ctrl_clr = ctrl_we && PWDATA[CTRL_CLR_BIT];
  end

  // APB state register; reset abandons a pending memory read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) apb_st <= APB_IDLE;
    else        apb_st <= apb_next;
  end

  // APB next-state: only a permitted memory read takes the wait state
  always_comb begin
    apb_next = apb_st;
    case (apb_st)
      APB_IDLE:     if (access && is_mem && !PWRITE && !start) apb_next = APB_MRD_WAIT;
      APB_MRD_WAIT: apb_next = APB_IDLE;
      default:      apb_next = APB_IDLE;
    endcase
  end

  // APB response, RAM port drive and register write strobes
  always_comb begin
    PREADY    = 1'b1;
    PSLVERR   = 1'b0;
    PRDATA    = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    ctrl_we   = 1'b0;
    cfg_we    = 1'b0;
    irqen_we  = 1'b0;
    case (apb_st)
      APB_IDLE: begin
        if (access) begin
          if (is_mem) begin
            if (start) begin
              PSLVERR = 1'b1;
            end else if (PWRITE) begin
              mem_en    = 1'b1;
              mem_we    = 1'b1;
              mem_be    = '1;
              mem_addr  = PADDR[MEM_ADDR_WIDTH+1:2];
              mem_wdata = PWDATA;
            end else begin
              mem_en   = 1'b1;
              mem_addr = PADDR[MEM_ADDR_WIDTH+1:2];
              PREADY   = 1'b0;
            end
          end else begin
            case (reg_off)
              ACC_REG_CTRL: begin
                if (PWRITE) begin
                  ctrl_we = 1'b1;
                  if (PWDATA[CTRL_GO_BIT] && start) PSLVERR = 1'b1;
                end
              end
              ACC_REG_STATUS: begin
                if (!PWRITE) PRDATA = MEM_DATA_WIDTH'(status_word);
              end
              ACC_REG_CFG: begin
                if (PWRITE) begin
                  if (start) PSLVERR = 1'b1;
                  else       cfg_we  = 1'b1;
                end else begin
                  PRDATA = MEM_DATA_WIDTH'({incr, max_cnt});
                end
              end
              ACC_REG_IRQEN: begin
                if (PWRITE) irqen_we = 1'b1;
                else        PRDATA   = MEM_DATA_WIDTH'(irq_en);
              end
              default: PSLVERR = 1'b1;
            endcase
          end
        end
      end
      APB_MRD_WAIT: PRDATA = mem_rdata;
      default: ;
    endcase
  end

  // Configuration registers and interrupt line; CLR drops irq on the next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_cnt <= '0;
      incr    <= '0;
      irq_en  <= 1'b0;
      irq_o   <= 1'b0;
    end else begin
      if (cfg_we) begin
        max_cnt <= PWDATA[7:0];
        incr    <= PWDATA[15:8];
      end
      if (irqen_we) irq_en <= PWDATA[0];
      irq_o <= irq_en && (done_flag || timeout_flag) && !ctrl_clr;
    end
  end

  accel_run_ctrl #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_run (
    .clk          (clk),
    .rst_n        (rst_n),
    .go           (ctrl_go),
    .clr          (ctrl_clr),
    .done         (done),
    .start        (start),
    .done_flag    (done_flag),
    .timeout_flag (timeout_flag)
  );

endmodule

// File: tb/tb_accel_apb_ctrl.sv
// Bench for accel_apb_ctrl: random APB traffic against a register/RAM/run-length model.
module tb_accel_apb_ctrl;
  import cfg_types_pkg::*;

  localparam int unsigned TMO = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, start, irq_o;
  logic        done = 1'b0;
  logic [7:0]  max_cnt, incr;
  acc_state_t  accel_state = ACC_IDLE;
  acc_error_t  accel_error = ACC_ERR_NONE;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [15:0] m_cfg = '0;
  logic        m_irq_en = 1'b0;
  logic        m_done = 1'b0;
  logic        m_tmo = 1'b0;
  logic [31:0] mem_ref [int];

  // monitors / models
  logic [31:0] ram [1024];
  int  done_after = 0;
  bit  done_en = 1'b0;
  int  acc_cnt = 0;
  int  cyc = 0, cur_len = 0, last_len = 0, busy_mem_en = 0;
  int  fall_cyc = -1, rise_cyc = -1;
  logic start_d = 1'b0, irq_d = 1'b0;
  logic first_mem_en;

  accel_apb_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .start(start), .done(done), .max_cnt(max_cnt), .incr(incr),
    .accel_state(accel_state), .accel_error(accel_error), .mem_en(mem_en),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  // RAM port-a behavioural model, one cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
      mem_rdata <= ram[mem_addr];
    end
  end

  // Accelerator model: pulses done after done_after cycles of start
  always @(posedge clk) begin
    if (start) acc_cnt = acc_cnt + 1;
    else       acc_cnt = 0;
    done <= done_en && (acc_cnt == done_after);
  end

  always @(posedge clk) cyc = cyc + 1;

  // Run-length, guard and interrupt-edge monitor
  always @(negedge clk) begin
    if (!rst_n) cur_len = 0;
    else if (start) cur_len = cur_len + 1;
    else if (cur_len != 0) begin
      last_len = cur_len;
      cur_len  = 0;
    end
    if (start && mem_en) busy_mem_en = busy_mem_en + 1;
    if (start_d && !start) fall_cyc = cyc;
    if (!irq_d && irq_o) rise_cyc = cyc;
    start_d = start;
    irq_d   = irq_o;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench stalled");
  end

  function automatic logic [31:0] exp_status(input logic busy);
    return {8'h00, 8'(accel_error), 8'(accel_state), 5'b0, m_tmo, m_done, busy};
  endfunction

  task automatic apb_xfer(input logic wr, input logic [12:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int waits);
    bit got;
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    waits = 0; got = 1'b0; rdata = '0; err = 1'b0;
    @(negedge clk);
    first_mem_en = mem_en;
    for (int i = 0; i < 8 && !got; i++) begin
      if (i > 0) @(negedge clk);
      if (PREADY) begin
        rdata = PRDATA; err = PSLVERR; got = 1'b1;
      end else begin
        waits++;
        checks++;
        if (PSLVERR !== 1'b0) begin
          failures++;
          $display("FAIL pslverr_in_wait addr=%h got=%b want=0", addr, PSLVERR);
        end
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL apb_no_ready addr=%h waited=%0d", addr, waits);
    end
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wait_run_end();
    bit ended = 1'b0;
    for (int i = 0; i < 200 && !ended; i++) begin
      @(negedge clk);
      if (!start) ended = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (!ended) begin
      failures++;
      $display("FAIL run_never_ended start=%b", start);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({start, mem_en, mem_we, mem_be, mem_addr, mem_wdata, max_cnt, incr, irq_o, PSLVERR, PRDATA} !== '0) begin
      failures++;
      $display("FAIL reset_outputs start=%b mem_en=%b cfg=%h irq=%b slverr=%b prdata=%h want all 0",
               start, mem_en, {incr, max_cnt}, irq_o, PSLVERR, PRDATA);
    end
    checks++;
    if (PREADY !== 1'b1) begin
      failures++;
      $display("FAIL reset_pready got=%b want=1", PREADY);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_mem_rw();
    logic [31:0] rd, wd; logic err; int w; logic [12:0] a;
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin a = 13'h1014; wd = 32'hDEADBEEF; end
      else begin a = {1'b1, 10'($urandom_range(0, 1023)), 2'b00}; wd = $urandom; end
      apb_xfer(1'b1, a, wd, rd, err, w);
      mem_ref[int'(a[11:2])] = wd;
      checks++;
      if (err !== 1'b0 || w != 0 || first_mem_en !== 1'b1) begin
        failures++;
        $display("FAIL mem_write a=%h err=%b waits=%0d mem_en=%b want 0/0/1", a, err, w, first_mem_en);
      end
      apb_xfer(1'b0, a, 32'h0, rd, err, w);
      checks++;
      if (rd !== mem_ref[int'(a[11:2])] || err !== 1'b0 || w != 1) begin
        failures++;
        $display("FAIL mem_read a=%h got=%h err=%b waits=%0d want=%h/0/1",
                 a, rd, err, w, mem_ref[int'(a[11:2])]);
      end
    end
  endtask

  task automatic test_regs();
    logic [31:0] rd, wd; logic err; int w; logic [12:0] a;
    for (int k = 0; k < 3; k++) begin
      wd = $urandom;
      apb_xfer(1'b1, 13'h008, wd, rd, err, w);
      m_cfg = wd[15:0];
      apb_xfer(1'b0, 13'h008, 32'h0, rd, err, w);
      checks++;
      if (rd !== {16'h0, m_cfg} || err !== 1'b0 || {incr, max_cnt} !== m_cfg) begin
        failures++;
        $display("FAIL cfg_rw got=%h outs=%h err=%b want=%h", rd, {incr, max_cnt}, err, m_cfg);
      end
    end
    wd = $urandom | 32'h1;
    apb_xfer(1'b1, 13'h00C, wd, rd, err, w);
    m_irq_en = wd[0];
    apb_xfer(1'b0, 13'h00C, 32'h0, rd, err, w);
    checks++;
    if (rd !== {31'h0, m_irq_en}) begin
      failures++;
      $display("FAIL irqen_rd got=%h want=%h", rd, {31'h0, m_irq_en});
    end
    apb_xfer(1'b1, 13'h00C, 32'h0, rd, err, w);
    m_irq_en = 1'b0;
    apb_xfer(1'b0, 13'h000, 32'h0, rd, err, w);
    checks++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      failures++;
      $display("FAIL ctrl_rd got=%h err=%b want 0/0", rd, err);
    end
    for (int k = 0; k < 3; k++) begin
      a = {1'b0, 10'($urandom_range(4, 1023)), 2'b00};
      apb_xfer(1'b1, a, $urandom, rd, err, w);
      checks++;
      if (err !== 1'b1 || w != 0) begin
        failures++;
        $display("FAIL bad_off_wr a=%h err=%b waits=%0d want 1/0", a, err, w);
      end
      apb_xfer(1'b0, a, 32'h0, rd, err, w);
      checks++;
      if (err !== 1'b1 || rd !== 32'h0) begin
        failures++;
        $display("FAIL bad_off_rd a=%h err=%b got=%h want 1/0", a, err, rd);
      end
    end
    apb_xfer(1'b0, 13'h008, 32'h0, rd, err, w);
    checks++;
    if (rd !== {16'h0, m_cfg}) begin
      failures++;
      $display("FAIL bad_off_side_effect cfg=%h want=%h", rd, m_cfg);
    end
  endtask

  // One accelerator run; probe exercises the busy guards while start is high
  task automatic do_run(input int n, input bit en, input logic [31:0] ctrl,
                        input logic [15:0] cfg, input bit probe);
    logic [31:0] rd; logic err; int w; int exp_len; bit by_done;
    accel_state = acc_state_t'(2'($urandom_range(0, 3)));
    accel_error = acc_error_t'(2'($urandom_range(0, 3)));
    apb_xfer(1'b1, 13'h008, {16'h0, cfg}, rd, err, w);
    m_cfg = cfg;
    done_after = n; done_en = en; busy_mem_en = 0;
    apb_xfer(1'b1, 13'h000, ctrl, rd, err, w);
    if (ctrl[1]) begin m_done = 1'b0; m_tmo = 1'b0; end
    m_done = 1'b0;
    checks++;
    if (err !== 1'b0 || start !== 1'b1) begin
      failures++;
      $display("FAIL go_accept err=%b start=%b want 0/1", err, start);
    end
    if (probe) begin
      apb_xfer(1'b0, 13'h1000, 32'h0, rd, err, w);
      checks++;
      if (err !== 1'b1 || rd !== 32'h0 || w != 0 || first_mem_en !== 1'b0) begin
        failures++;
        $display("FAIL busy_mem_rd err=%b rd=%h waits=%0d mem_en=%b want 1/0/0/0", err, rd, w, first_mem_en);
      end
      apb_xfer(1'b1, 13'h008, $urandom, rd, err, w);
      checks++;
      if (err !== 1'b1) begin
        failures++;
        $display("FAIL busy_cfg_wr err=%b want=1", err);
      end
      apb_xfer(1'b0, 13'h008, 32'h0, rd, err, w);
      checks++;
      if (rd !== {16'h0, m_cfg} || err !== 1'b0 || {incr, max_cnt} !== m_cfg) begin
        failures++;
        $display("FAIL busy_cfg_rd got=%h outs=%h want=%h", rd, {incr, max_cnt}, m_cfg);
      end
      apb_xfer(1'b1, 13'h000, 32'h1, rd, err, w);
      checks++;
      if (err !== 1'b1) begin
        failures++;
        $display("FAIL busy_go err=%b want=1", err);
      end
      apb_xfer(1'b0, 13'h004, 32'h0, rd, err, w);
      checks++;
      if (rd !== exp_status(1'b1)) begin
        failures++;
        $display("FAIL busy_status got=%h want=%h", rd, exp_status(1'b1));
      end
    end
    wait_run_end();
    by_done = en && (n + 1 <= int'(TMO));
    exp_len = by_done ? n + 1 : int'(TMO);
    if (by_done) m_done = 1'b1;
    else         m_tmo  = 1'b1;
    checks++;
    if (last_len != exp_len) begin
      failures++;
      $display("FAIL run_length n=%0d got=%0d want=%0d", n, last_len, exp_len);
    end
    apb_xfer(1'b0, 13'h004, 32'h0, rd, err, w);
    checks++;
    if (rd !== exp_status(1'b0)) begin
      failures++;
      $display("FAIL end_status got=%h want=%h", rd, exp_status(1'b0));
    end
    checks++;
    if (busy_mem_en != 0 || irq_o !== (m_irq_en & (m_done | m_tmo))) begin
      failures++;
      $display("FAIL end_guard_irq mem_en_cycles=%0d irq=%b want 0/%b",
               busy_mem_en, irq_o, m_irq_en & (m_done | m_tmo));
    end
  endtask

  task automatic test_run_done();
    do_run(20, 1'b1, 32'h1, 16'h0304, 1'b1);
    checks++;
    if (max_cnt !== 8'd4 || incr !== 8'd3) begin
      failures++;
      $display("FAIL cfg_outputs max_cnt=%0d incr=%0d want 4/3", max_cnt, incr);
    end
    for (int k = 0; k < 3; k++)
      do_run($urandom_range(18, 22), 1'b1, 32'h1, 16'($urandom), 1'b1);
    do_run(int'(TMO) - 1, 1'b1, 32'h1, 16'($urandom), 1'b0);
  endtask

  task automatic test_timeout();
    do_run(0, 1'b0, 32'h1, 16'($urandom), 1'b1);
    do_run($urandom_range(2, 10), 1'b1, 32'h3, 16'($urandom), 1'b0);
  endtask

  task automatic test_irq();
    logic [31:0] rd; logic err; int w;
    apb_xfer(1'b1, 13'h00C, 32'h1, rd, err, w);
    m_irq_en = 1'b1;
    fall_cyc = -1; rise_cyc = -1;
    do_run($urandom_range(3, 10), 1'b1, 32'h1, 16'($urandom), 1'b0);
    checks++;
    if (rise_cyc - fall_cyc != 1 || fall_cyc < 0) begin
      failures++;
      $display("FAIL irq_latency fall=%0d rise=%0d want rise=fall+1", fall_cyc, rise_cyc);
    end
    apb_xfer(1'b1, 13'h000, 32'h2, rd, err, w);
    m_done = 1'b0; m_tmo = 1'b0;
    @(negedge clk);
    checks++;
    if (irq_o !== 1'b0) begin
      failures++;
      $display("FAIL irq_clr got=%b want=0", irq_o);
    end
    apb_xfer(1'b0, 13'h004, 32'h0, rd, err, w);
    checks++;
    if (rd !== exp_status(1'b0)) begin
      failures++;
      $display("FAIL clr_status got=%h want=%h", rd, exp_status(1'b0));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, wd; logic err; int w; int idx; int keys [$];
    for (int k = 0; k < 12; k++) begin
      if (($urandom_range(0, 1) == 0) || keys.size() == 0) begin
        idx = $urandom_range(0, 1023); wd = $urandom;
        apb_xfer(1'b1, {1'b1, 10'(idx), 2'b00}, wd, rd, err, w);
        mem_ref[idx] = wd; keys.push_back(idx);
        checks++;
        if (err !== 1'b0 || w != 0) begin
          failures++;
          $display("FAIL b2b_wr idx=%0d err=%b waits=%0d want 0/0", idx, err, w);
        end
      end else begin
        idx = keys[$urandom_range(0, keys.size() - 1)];
        apb_xfer(1'b0, {1'b1, 10'(idx), 2'b00}, 32'h0, rd, err, w);
        checks++;
        if (rd !== mem_ref[idx] || err !== 1'b0 || w != 1) begin
          failures++;
          $display("FAIL b2b_rd idx=%0d got=%h err=%b waits=%0d want=%h", idx, rd, err, w, mem_ref[idx]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] rd; logic err; int w;
    apb_xfer(1'b1, 13'h00C, 32'h1, rd, err, w);
    apb_xfer(1'b1, 13'h008, $urandom | 32'h0101, rd, err, w);
    done_en = 1'b0;
    apb_xfer(1'b1, 13'h000, 32'h1, rd, err, w);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (start !== 1'b0 || PREADY !== 1'b1) begin
      failures++;
      $display("FAIL async_reset start=%b pready=%b want 0/1", start, PREADY);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_cfg = '0; m_irq_en = 1'b0; m_done = 1'b0; m_tmo = 1'b0;
    apb_xfer(1'b0, 13'h004, 32'h0, rd, err, w);
    checks++;
    if (rd !== exp_status(1'b0)) begin
      failures++;
      $display("FAIL reset_status got=%h want=%h", rd, exp_status(1'b0));
    end
    apb_xfer(1'b0, 13'h008, 32'h0, rd, err, w);
    checks++;
    if (rd !== 32'h0 || irq_o !== 1'b0 || start !== 1'b0) begin
      failures++;
      $display("FAIL reset_cfg cfg=%h irq=%b start=%b want 0/0/0", rd, irq_o, start);
    end
  endtask

  initial begin
    test_reset();
    test_mem_rw();
    test_regs();
    test_run_done();
    test_timeout();
    test_irq();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accel_apb_ctrl.md
Name: accel_apb_ctrl

Overview:
- APB slave that sits between the PULPino peripheral bus and accel_wrapper.
- Toward the bus it is the responder; toward the accelerator it is the initiator. It drives start/max_cnt/incr, observes done/accel_state/accel_error, and maps the accelerator RAM port-a window into APB address space.
- Holds start high for the whole accelerator run and guards the RAM window while the accelerator owns the port.
- Adds a sticky completion flag, a level interrupt and a watchdog abort.

Parameters:
- APB_ADDR_WIDTH, 13, PADDR width; PADDR[12]=1 selects the memory window, PADDR[12]=0 selects registers.
- MEM_ADDR_WIDTH, 10, RAM word address width; equals PADDR[11:2].
- MEM_DATA_WIDTH, 32, RAM/APB data width.
- TIMEOUT_CYCLES, 65535, maximum run length in cycles before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- PADDR  in  APB_ADDR_WIDTH  APB address
- PWDATA  in  32  APB write data
- PWRITE  in  1  APB write
- PSEL  in  1  APB select
- PENABLE  in  1  APB enable
- PRDATA  out  32  APB read data
- PREADY  out  1  APB ready
- PSLVERR  out  1  APB error
- start  out  1  accelerator run / RAM port-a ownership
- done  in  1  accelerator completion
- max_cnt  out  8  accelerator config
- incr  out  8  accelerator config
- accel_state  in  acc_state_t  accelerator FSM state
- accel_error  in  acc_error_t  accelerator error code
- mem_en  out  1  RAM enable
- mem_addr  out  MEM_ADDR_WIDTH  RAM word address
- mem_we  out  1  RAM write enable
- mem_be  out  4  RAM byte enables
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid 1 cycle after mem_en
- irq_o  out  1  level interrupt

Behaviour:
- Reset: every output is 0, except PREADY=1 while idle. The registers reset as follows: max_cnt=0, incr=0, irq_en=0, done_flag=0, timeout_flag=0, run counter=0.
- Register map (word offsets):
  - 0x000 CTRL: W bit0 GO, W bit1 CLR (clears done_flag and timeout_flag); reads 0.
  - 0x004 STATUS: RO; bit0 busy(=start), bit1 done_flag, bit2 timeout_flag, [15:8] accel_state, [23:16] accel_error, zero-extended.
  - 0x008 CFG: RW; [7:0] max_cnt, [15:8] incr.
  - 0x00C IRQ_EN: RW bit0.
  - Any other register offset: PSLVERR=1, PRDATA=0, no side effect.
- Register accesses have zero wait states: PREADY=1 in the first access cycle (PSEL&PENABLE).
- Memory write:
  - The first access cycle drives mem_en=1, mem_we=1, mem_be=4'hF, mem_addr=PADDR[11:2], mem_wdata=PWDATA.
  - PREADY=1 in the same cycle.
- Memory read:
  - Access cycle 1 drives mem_en=1, mem_we=0, PREADY=0.
  - Access cycle 2 drives PREADY=1 with PRDATA=mem_rdata.
  - Exactly one wait state.
- APB FSM states: IDLE, MRD_WAIT.
  - IDLE→MRD_WAIT on a memory read in access cycle 1.
  - MRD_WAIT→IDLE unconditionally.
- Memory access while busy=1: PSLVERR=1, PREADY=1 in the first access cycle. mem_en stays 0 and PRDATA=0.
- CFG write while busy=1 is ignored and returns PSLVERR. CFG reads are always allowed.
- Run FSM states: STOPPED, RUNNING.
  - GO written while STOPPED: start=1 from the next cycle, run counter cleared, done_flag cleared.
  - GO written while RUNNING: PSLVERR, ignored.
  - While RUNNING, done=1 sampled: start=0 next cycle, done_flag=1, go to STOPPED.
  - While RUNNING, run counter reaching TIMEOUT_CYCLES (with TIMEOUT_CYCLES≠0) before done: start=0, timeout_flag=1, done_flag unchanged, go to STOPPED.
  - If done and timeout occur in the same cycle, done wins.
- Run counter: 16-bit, counts only while RUNNING, saturates at 16'hFFFF.
- Simultaneous GO and CLR in one write: CLR is applied first, then GO.
- irq_o = irq_en & (done_flag | timeout_flag). It is registered and stays asserted until CLR is written.
- PSLVERR is 0 whenever PREADY=0 and outside access cycles.
- Reset mid-run: start drops asynchronously, all flags clear, any pending APB read is abandoned.

Decomposition:
- Shared package cfg_types_pkg takes the following additions; acc_state_t and acc_error_t are already defined there:
  - Register offset constants: ACC_REG_CTRL, ACC_REG_STATUS, ACC_REG_CFG, ACC_REG_IRQEN.
  - CTRL and STATUS bit-index constants.
  - Enums apb_st_t and run_st_t.
- One sub-module is natural: accel_run_ctrl, containing the run FSM, watchdog counter and flags. Its inputs are go, clr, done; its outputs are start, done_flag, timeout_flag.

Test Plan:
- Write 0xDEADBEEF to mem word 5 (PADDR 0x1014), then read it back → the write completes with 0 wait states; the read has 1 wait state and returns 0xDEADBEEF; PSLVERR=0 on both.
- Write CFG 0x0000_0304 then GO; the accel model asserts done after 20 cycles → max_cnt=4 and incr=3. start stays high for 20+1 cycles. STATUS then reads bit1=1, bit0=0.
- During the run, read mem 0x1000 and write CFG → both return PSLVERR=1; mem_en stays 0 and CFG still reads 0x0304.
- TIMEOUT_CYCLES=8 and done is never asserted → start falls after 8 RUNNING cycles; STATUS bit2=1, bit1=0.
- IRQ_EN=1 and the run completes → irq_o=1 the cycle after done_flag sets. Writing CTRL=0x2 gives irq_o=0 on the next cycle.
- Assert rst_n=0 mid-run for 1 cycle → start=0 immediately; STATUS=0 apart from the accel_state/accel_error fields; CFG=0.
